// File: rtl/biriscv_csr_issue_arb.sv
// ---------------------------------------------------------------------------
// biriscv_csr_issue_arb
//
// Shares the single CSR execution unit between the two issue lanes of the
// dual-issue pipeline. At most one CSR-class instruction is granted per
// cycle, always oldest-first (lane 0 ahead of lane 1). Any instruction that
// can alter CSR or privilege state puts the arbiter into DRAIN, which blocks
// further CSR issue until that instruction has reached writeback.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   laneN_valid_i                lane N presents a CSR-class instruction
//   laneN_opcode_i / _pc_i       lane N instruction word and PC
//   laneN_invalid_i              lane N instruction decoded as illegal
//   laneN_ra_operand_i           lane N rs1 value
//   stall_i                      pipeline stall: no issue, drain holds
//   flush_i                      pipeline flush: back to IDLE, no issue
//   laneN_accept_o               lane N issued this cycle
//   csr_*_o                      granted lane's fields to the CSR unit
//                                (all zero when nothing is granted)
//   csr_lane_o                   which lane was granted
//   busy_o                       arbiter is draining a serialising op
//   blocked_cycles_o             saturating count of cycles in which a
//                                valid lane was left unissued
// ---------------------------------------------------------------------------
module biriscv_csr_issue_arb #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lane0_valid_i,
    input  logic [31:0] lane0_opcode_i,
    input  logic [31:0] lane0_pc_i,
    input  logic        lane0_invalid_i,
    input  logic [31:0] lane0_ra_operand_i,
    input  logic        lane1_valid_i,
    input  logic [31:0] lane1_opcode_i,
    input  logic [31:0] lane1_pc_i,
    input  logic        lane1_invalid_i,
    input  logic [31:0] lane1_ra_operand_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        lane0_accept_o,
    output logic        lane1_accept_o,
    output logic        csr_valid_o,
    output logic [31:0] csr_opcode_o,
    output logic [31:0] csr_pc_o,
    output logic        csr_invalid_o,
    output logic [4:0]  csr_rd_idx_o,
    output logic [4:0]  csr_ra_idx_o,
    output logic [4:0]  csr_rb_idx_o,
    output logic [31:0] csr_ra_operand_o,
    output logic        csr_lane_o,
    output logic        busy_o,
    output logic [31:0] blocked_cycles_o
);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_DRAIN = 1'b1;

    localparam logic [3:0]  DRAIN_LOAD = 4'(DRAIN_CYCLES);

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
    localparam logic [31:0] INST_WFI    = 32'h1050_0073;

    logic [0:0]  state_q;
    logic [3:0]  drain_q;
    logic [31:0] blocked_q;
    logic        grant_en;
    logic        grant_serialising;
    logic        blocked_now;

    // Decide whether an instruction may change CSR or privilege state. Set and
    // clear forms with rs1/uimm of zero are pure reads and may issue freely;
    // illegal instructions are treated as serialising because they trap.
    function automatic logic is_serialising(input logic [31:0] op, input logic inv);
        logic is_system;
        logic is_csr_write;
        logic is_csr_setclr;
        logic is_priv;
        logic is_fencei;
        is_system     = (op[6:0] == 7'b1110011);
        is_csr_write  = is_system && ((op[14:12] == 3'b001) || (op[14:12] == 3'b101));
        is_csr_setclr = is_system && op[13] && (op[19:15] != 5'd0);
        is_priv       = (op == INST_ECALL) || (op == INST_EBREAK) ||
                        (op == INST_MRET)  || (op == INST_WFI);
        is_fencei     = (op[6:0] == 7'b0001111) && (op[14:12] == 3'b001);
        return inv || is_csr_write || is_csr_setclr || is_priv || is_fencei;
    endfunction

    // Issue is only possible from IDLE in a cycle that is not stalled,
    // flushed or in reset; lane 1 only goes when lane 0 has nothing, which
    // keeps CSR side effects in program order.
    assign grant_en       = (state_q == STATE_IDLE) && !stall_i && !flush_i && !rst_i;
    assign lane0_accept_o = grant_en && lane0_valid_i;
    assign lane1_accept_o = grant_en && lane1_valid_i && !lane0_valid_i;
    assign csr_valid_o    = lane0_accept_o | lane1_accept_o;
    assign busy_o         = (state_q == STATE_DRAIN);
    assign blocked_cycles_o = blocked_q;

    // Steer the granted lane onto the CSR unit inputs; everything is driven
    // to zero when no lane is granted so the unit sees a clean idle bus.
    always_comb begin
        csr_opcode_o     = 32'd0;
        csr_pc_o         = 32'd0;
        csr_invalid_o    = 1'b0;
        csr_ra_operand_o = 32'd0;
        csr_lane_o       = 1'b0;
        if (lane0_accept_o) begin
            csr_opcode_o     = lane0_opcode_i;
            csr_pc_o         = lane0_pc_i;
            csr_invalid_o    = lane0_invalid_i;
            csr_ra_operand_o = lane0_ra_operand_i;
        end else if (lane1_accept_o) begin
            csr_opcode_o     = lane1_opcode_i;
            csr_pc_o         = lane1_pc_i;
            csr_invalid_o    = lane1_invalid_i;
            csr_ra_operand_o = lane1_ra_operand_i;
            csr_lane_o       = 1'b1;
        end
    end

    assign csr_rd_idx_o = csr_opcode_o[11:7];
    assign csr_ra_idx_o = csr_opcode_o[19:15];
    assign csr_rb_idx_o = csr_opcode_o[24:20];

    assign grant_serialising = csr_valid_o && is_serialising(csr_opcode_o, csr_invalid_o);

    // IDLE/DRAIN control. A serialising grant loads the drain counter, which
    // only advances on unstalled cycles so the blockout tracks the real
    // progress of the instruction to writeback. Flush abandons the drain
    // since the in-flight instruction is being discarded or has already
    // redirected the pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_q <= STATE_IDLE;
            drain_q <= 4'd0;
        end else if (state_q == STATE_IDLE) begin
            if (grant_serialising) begin
                state_q <= STATE_DRAIN;
                drain_q <= DRAIN_LOAD;
            end
        end else if (!stall_i) begin
            drain_q <= drain_q - 4'd1;
            if (drain_q == 4'd1) begin
                state_q <= STATE_IDLE;
            end
        end
    end

    assign blocked_now = !flush_i &&
                         ((lane0_valid_i && !lane0_accept_o) ||
                          (lane1_valid_i && !lane1_accept_o));

    // Performance counter of lost issue opportunities; it sticks at all-ones
    // rather than wrapping so long runs never report a misleading small value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            blocked_q <= 32'd0;
        end else if (blocked_now && (blocked_q != 32'hFFFF_FFFF)) begin
            blocked_q <= blocked_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_biriscv_csr_issue_arb.sv
// ---------------------------------------------------------------------------
// tb_biriscv_csr_issue_arb
//
// Directed bench for the CSR issue arbiter. Each cycle the stimulus and the
// outcome expected for it are pushed together; the outcome is popped and
// compared once the combinational outputs have settled mid-cycle.
// ---------------------------------------------------------------------------
module tb_biriscv_csr_issue_arb;

    localparam logic [31:0] OP_NONE       = 32'h0000_0000;
    localparam logic [31:0] OP_RD_MCYCLE5 = 32'hB000_22F3;
    localparam logic [31:0] OP_RD_MCYCLE6 = 32'hB000_2373;
    localparam logic [31:0] OP_CSRRW_MST  = 32'h3000_9073;
    localparam logic [31:0] OP_CSRRSI_U0  = 32'h3000_63F3;
    localparam logic [31:0] OP_CSRRSI_U4  = 32'h3002_63F3;
    localparam logic [31:0] OP_ECALL      = 32'h0000_0073;
    localparam logic [31:0] OP_MRET       = 32'h3020_0073;

    typedef struct {
        logic        acc0;
        logic        acc1;
        logic        valid;
        logic        lane;
        logic [31:0] opcode;
        logic [31:0] pc;
        logic        invalid;
        logic [31:0] operand;
        logic        busy;
        logic [31:0] blocked;
        logic        chkState;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        lane0Valid, lane1Valid;
    logic [31:0] lane0Opcode, lane1Opcode;
    logic [31:0] lane0Pc, lane1Pc;
    logic        lane0Invalid, lane1Invalid;
    logic [31:0] lane0Operand, lane1Operand;
    logic        stall, flush;
    logic        lane0Accept, lane1Accept;
    logic        csrValid;
    logic [31:0] csrOpcode, csrPc, csrOperand;
    logic        csrInvalid;
    logic [4:0]  csrRdIdx, csrRaIdx, csrRbIdx;
    logic        csrLane;
    logic        busy;
    logic [31:0] blockedCycles;

    exp_t expQueue[$];
    int   checks   = 0;
    int   errors   = 0;
    int   stepNum  = 0;

    biriscv_csr_issue_arb #(.DRAIN_CYCLES(3)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .lane0_valid_i      (lane0Valid),
        .lane0_opcode_i     (lane0Opcode),
        .lane0_pc_i         (lane0Pc),
        .lane0_invalid_i    (lane0Invalid),
        .lane0_ra_operand_i (lane0Operand),
        .lane1_valid_i      (lane1Valid),
        .lane1_opcode_i     (lane1Opcode),
        .lane1_pc_i         (lane1Pc),
        .lane1_invalid_i    (lane1Invalid),
        .lane1_ra_operand_i (lane1Operand),
        .stall_i            (stall),
        .flush_i            (flush),
        .lane0_accept_o     (lane0Accept),
        .lane1_accept_o     (lane1Accept),
        .csr_valid_o        (csrValid),
        .csr_opcode_o       (csrOpcode),
        .csr_pc_o           (csrPc),
        .csr_invalid_o      (csrInvalid),
        .csr_rd_idx_o       (csrRdIdx),
        .csr_ra_idx_o       (csrRaIdx),
        .csr_rb_idx_o       (csrRbIdx),
        .csr_ra_operand_o   (csrOperand),
        .csr_lane_o         (csrLane),
        .busy_o             (busy),
        .blocked_cycles_o   (blockedCycles)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counted, then asserted with a tagged report on failure.
    task automatic checkField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s step %0d: observed %h expected %h", tag, stepNum, observed, expected);
        end
    endtask

    // Drive one cycle of stimulus just after the rising edge and queue the
    // outcome it should produce, including the granted lane's fields.
    task automatic applyStimulus(
        input logic v0, input logic [31:0] op0, input logic inv0,
        input logic v1, input logic [31:0] op1, input logic inv1,
        input logic st, input logic fl, input logic rs,
        input logic e0, input logic e1, input logic eBusy,
        input logic [31:0] eBlocked, input logic chk
    );
        exp_t e;
        @(posedge clk);
        #1;
        stepNum++;
        lane0Valid   = v0;
        lane0Opcode  = op0;
        lane0Invalid = inv0;
        lane0Pc      = 32'h0000_1000 + 32'(stepNum) * 8;
        lane0Operand = $urandom;
        lane1Valid   = v1;
        lane1Opcode  = op1;
        lane1Invalid = inv1;
        lane1Pc      = lane0Pc + 32'd4;
        lane1Operand = $urandom;
        stall        = st;
        flush        = fl;
        rst          = rs;
        e.acc0     = e0;
        e.acc1     = e1;
        e.valid    = e0 | e1;
        e.lane     = e1;
        e.opcode   = e0 ? op0 : (e1 ? op1 : 32'd0);
        e.pc       = e0 ? lane0Pc : (e1 ? lane1Pc : 32'd0);
        e.invalid  = e0 ? inv0 : (e1 ? inv1 : 1'b0);
        e.operand  = e0 ? lane0Operand : (e1 ? lane1Operand : 32'd0);
        e.busy     = eBusy;
        e.blocked  = eBlocked;
        e.chkState = chk;
        expQueue.push_back(e);
    endtask

    // Mid-cycle, pop the pending expectation and compare every output.
    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        checks++;
        assert (expQueue.size() != 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard step %0d: observed empty queue expected entry", stepNum);
        end
        if (expQueue.size() != 0) begin
            e = expQueue.pop_front();
            checkField("lane0_accept", 32'(lane0Accept), 32'(e.acc0));
            checkField("lane1_accept", 32'(lane1Accept), 32'(e.acc1));
            checkField("csr_valid",    32'(csrValid),    32'(e.valid));
            checkField("csr_lane",     32'(csrLane),     32'(e.lane));
            checkField("csr_opcode",   csrOpcode,        e.opcode);
            checkField("csr_pc",       csrPc,            e.pc);
            checkField("csr_invalid",  32'(csrInvalid),  32'(e.invalid));
            checkField("csr_operand",  csrOperand,       e.operand);
            checkField("csr_rd_idx",   32'(csrRdIdx),    32'(e.opcode[11:7]));
            checkField("csr_ra_idx",   32'(csrRaIdx),    32'(e.opcode[19:15]));
            checkField("csr_rb_idx",   32'(csrRbIdx),    32'(e.opcode[24:20]));
            if (e.chkState) begin
                checkField("busy",           32'(busy),     32'(e.busy));
                checkField("blocked_cycles", blockedCycles, e.blocked);
            end
        end
    endtask

    // One directed cycle: drive, then compare.
    task automatic cycle(
        input logic v0, input logic [31:0] op0, input logic inv0,
        input logic v1, input logic [31:0] op1, input logic inv1,
        input logic st, input logic fl, input logic rs,
        input logic e0, input logic e1, input logic eBusy,
        input logic [31:0] eBlocked, input logic chk
    );
        applyStimulus(v0, op0, inv0, v1, op1, inv1, st, fl, rs, e0, e1, eBusy, eBlocked, chk);
        checkOutput();
    endtask

    // Quiet cycle with no lane valid: only state outputs are of interest.
    task automatic idleCycle(input logic eBusy, input logic [31:0] eBlocked);
        cycle(0, OP_NONE, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, eBusy, eBlocked, 1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        lane0Valid = 1'b0; lane0Opcode = 32'd0; lane0Pc = 32'd0; lane0Invalid = 1'b0; lane0Operand = 32'd0;
        lane1Valid = 1'b0; lane1Opcode = 32'd0; lane1Pc = 32'd0; lane1Invalid = 1'b0; lane1Operand = 32'd0;

        $display("[TB] reset with lane 0 presenting");
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 1, 0, 0, 0, 0, 1);

        $display("[TB] two pure reads, oldest first, back to back");
        cycle(1, OP_RD_MCYCLE5, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        cycle(0, OP_NONE,       0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 1, 0, 1, 1);
        idleCycle(0, 1);

        $display("[TB] CSRRW drains three cycles before the next read");
        cycle(0, OP_NONE, 0, 0, OP_NONE, 0, 0, 0, 1, 0, 0, 0, 1, 1);
        cycle(1, OP_CSRRW_MST,  0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 3, 1);
        idleCycle(0, 3);

        $display("[TB] CSRRW drain extended by one stalled cycle");
        cycle(0, OP_NONE, 0, 0, OP_NONE, 0, 0, 0, 1, 0, 0, 0, 3, 1);
        cycle(1, OP_CSRRW_MST,  0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 1, 0, 0, 0, 0, 1, 1, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 2, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 0, 0, 1, 3, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 4, 1);
        idleCycle(0, 4);

        $display("[TB] CSRRSI uimm 0 is a read, uimm 4 serialises");
        cycle(1, OP_CSRRSI_U0, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 4, 1);
        cycle(1, OP_CSRRSI_U0, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 4, 1);
        cycle(1, OP_CSRRSI_U4, 0, 0, OP_NONE, 0, 0, 0, 0, 1, 0, 0, 4, 1);
        idleCycle(1, 4);
        idleCycle(1, 4);
        idleCycle(1, 4);
        idleCycle(0, 4);

        $display("[TB] ECALL drain cut short by flush");
        cycle(1, OP_ECALL, 0, 0, OP_NONE,       0, 0, 0, 0, 1, 0, 0, 4, 1);
        cycle(0, OP_NONE,  0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 0, 1, 4, 1);
        cycle(0, OP_NONE,  0, 1, OP_RD_MCYCLE6, 0, 0, 1, 0, 0, 0, 1, 5, 1);
        cycle(0, OP_NONE,  0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 1, 0, 5, 1);

        $display("[TB] stall with both lanes, illegal lane 0, lane 1 MRET");
        cycle(1, OP_RD_MCYCLE5, 0, 1, OP_RD_MCYCLE6, 0, 1, 0, 0, 0, 0, 0, 5, 1);
        cycle(1, OP_RD_MCYCLE5, 1, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 1, 0, 0, 6, 1);
        cycle(0, OP_NONE, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 0, 1, 7, 1);
        cycle(0, OP_NONE, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 0, 1, 8, 1);
        cycle(0, OP_NONE, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 0, 1, 9, 1);
        cycle(0, OP_NONE, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 0, 0, 1, 0, 10, 1);
        cycle(0, OP_NONE, 0, 1, OP_MRET,       0, 0, 0, 0, 0, 1, 0, 10, 1);
        idleCycle(1, 10);

        $display("[TB] reset in the middle of a drain");
        cycle(1, OP_RD_MCYCLE5, 0, 1, OP_RD_MCYCLE6, 0, 0, 0, 1, 0, 0, 1, 10, 1);
        cycle(1, OP_RD_MCYCLE5, 0, 0, OP_NONE,       0, 0, 0, 0, 1, 0, 0, 0, 1);
        idleCycle(0, 0);

        checks++;
        assert (expQueue.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: observed %0d leftover expected 0", expQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/biriscv_csr_issue_arb.md
# biriscv_csr_issue_arb

Issue scheduler that shares the single CSR execution unit between the two issue lanes of the dual-issue pipeline. It grants at most one CSR-class instruction per cycle, always oldest-first (lane 0 before lane 1). It serialises every instruction that can change CSR or privilege state by holding off further CSR issue until that instruction has drained through writeback. It sits between the issue stage and the CSR unit and drives that unit's opcode inputs.

## Interface
- DRAIN_CYCLES, 3, cycles from CSR-unit issue to CSR writeback commit; legal range 1..15.
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- lane0_valid_i  in  1  lane 0 (older) presents a CSR-class instruction.
- lane0_opcode_i  in  32  lane 0 instruction word.
- lane0_pc_i  in  32  lane 0 PC.
- lane0_invalid_i  in  1  lane 0 instruction decoded as illegal.
- lane0_ra_operand_i  in  32  lane 0 rs1 value.
- lane1_valid_i / lane1_opcode_i / lane1_pc_i / lane1_invalid_i / lane1_ra_operand_i  in  1/32/32/1/32  same fields for lane 1 (younger).
- stall_i  in  1  pipeline stalled; no issue, drain does not advance.
- flush_i  in  1  pipeline flush (exception, mret or branch at writeback).
- lane0_accept_o  out  1  lane 0 instruction issued this cycle.
- lane1_accept_o  out  1  lane 1 instruction issued this cycle.
- csr_valid_o  out  1  opcode valid to the CSR unit.
- csr_opcode_o  out  32  muxed instruction word.
- csr_pc_o  out  32  muxed PC.
- csr_invalid_o  out  1  muxed illegal flag.
- csr_rd_idx_o / csr_ra_idx_o / csr_rb_idx_o  out  5 each  opcode bits [11:7] / [19:15] / [24:20] of the muxed word.
- csr_ra_operand_o  out  32  muxed rs1 value.
- csr_lane_o  out  1  lane that was granted (0/1).
- busy_o  out  1  arbiter is in DRAIN.
- blocked_cycles_o  out  32  count of cycles in which a valid lane was not accepted.

## Operation
- States: IDLE and DRAIN. A 4-bit counter drain_q is used in DRAIN.
- Grant enable (en): state==IDLE && !stall_i && !flush_i && !rst_i.
- Lane 0 grant: en && lane0_valid_i.
- Lane 1 grant: en && lane1_valid_i && !lane0_valid_i. Lane 1 is never granted in the same cycle as lane 0, and never while lane 0 is valid.
- csr_valid_o = lane0_accept_o | lane1_accept_o.
- Mux outputs carry the granted lane's fields. When nothing is granted, all mux outputs and csr_lane_o are 0.
- A granted instruction is serialising if any of the following holds:
  - it is CSRRW or CSRRWI;
  - it is CSRRS, CSRRC, CSRRSI or CSRRCI with bits [19:15] != 0;
  - it is ECALL, EBREAK, MRET, WFI or FENCE.I;
  - its invalid flag is set.
- A pure CSR read (set/clear with bits [19:15] == 0) or any other CSR-class opcode is non-serialising.
- IDLE → DRAIN on the grant of a serialising instruction; drain_q loads DRAIN_CYCLES.
- In DRAIN:
  - drain_q decrements on every cycle with !stall_i.
  - When drain_q==1 and !stall_i, the next state is IDLE.
  - While stall_i is high, drain_q holds.
- flush_i (any state): next state is IDLE and drain_q becomes 0. No grant occurs in the flush cycle.
- blocked_cycles_o increments when !flush_i and ((lane0_valid_i && !lane0_accept_o) || (lane1_valid_i && !lane1_accept_o)). It saturates at 0xFFFFFFFF.
- busy_o = (state==DRAIN).

## Timing
- Grants and mux outputs are combinational from the current inputs and the registered state: zero-latency issue.
- Non-serialising instructions issue back-to-back, one per cycle.
- A serialising grant at cycle T (no stall) blocks all grants in cycles T+1..T+DRAIN_CYCLES. The next grant is possible at T+DRAIN_CYCLES+1.
- Each stalled cycle during DRAIN extends the blockout by one cycle.
- Reset: at the first clock edge with rst_i high, state becomes IDLE, drain_q becomes 0, and blocked_cycles_o becomes 0. While rst_i is high, all accepts and csr_valid_o are 0 and all mux outputs are 0. busy_o reads 0 after that first reset edge.
- Simultaneous events:
  - flush_i takes priority over any grant and over the DRAIN countdown.
  - stall_i with both lanes valid grants nothing, and blocked_cycles_o increments.
- Reset in the middle of DRAIN returns the block to IDLE on the next edge.

## Test plan
- Both lanes valid; lane 0 is CSRRS x5,mcycle,x0; lane 1 is CSRRS x6,mcycle,x0; no stall → cycle 0: lane0_accept_o=1, csr_lane_o=0. Cycle 1 (lane 1 still valid): lane1_accept_o=1, csr_lane_o=1. busy_o stays 0 and blocked_cycles_o=1.
- Lane 0 CSRRW mstatus at cycle 0 with DRAIN_CYCLES=3, followed by a read held valid → busy_o=1 in cycles 1-3, no accepts in cycles 1-3, and the read is accepted in cycle 4. blocked_cycles_o=3.
- Same as the previous scenario with stall_i high in cycle 2 → the read is accepted in cycle 5, and drain_q holds across the stalled cycle.
- CSRRSI with uimm=0 → non-serialising. The same instruction with uimm=4 → serialising, and busy_o rises the next cycle.
- ECALL granted, then flush_i in cycle 2 → busy_o=0 in cycle 3, and a valid CSR read is accepted in cycle 3. No grant occurs in cycle 2.
- rst_i asserted mid-DRAIN with lanes valid → accepts are 0 during reset. After release: IDLE, blocked_cycles_o=0, and the first valid lane 0 instruction is accepted immediately.
